fifo_ctrl5_32: RTL and testbench
================================

// Module: fifo_ctrl5_32
// PURPOSE
//  Pointer/flag controller for the 32-entry 8-bit register-file FIFO.
//  Drives write word-select (wr_addr + wr_sel_en into decoder5_32) and
//  read-mux select. Arbitrates simultaneous write/read requests and keeps
//  occupancy, threshold flags and sticky overflow/underflow errors.
//  Sits between the producer/consumer handshakes and the storage array.
// PARAMETERS
//  ADDR_W     5   pointer width; depth = 2**ADDR_W (32); fixed by decoder5_32
//  AFULL_TH   28  almost_full asserted when count >= AFULL_TH
//  AEMPTY_TH  4   almost_empty asserted when count <= AEMPTY_TH
// PORTS
//  clk           in   1  rising-edge clock, single domain
//  rst           in   1  synchronous, active-high reset
//  wr_req        in   1  producer requests a write this cycle
//  rd_req        in   1  consumer requests a read this cycle
//  err_clr       in   1  clears ovf_err/udf_err (one-cycle pulse)
//  wr_ack        out  1  write accepted this cycle (combinational)
//  rd_ack        out  1  read accepted this cycle (combinational)
//  wr_sel_en     out  1  enable to decoder5_32; equals wr_ack
//  wr_addr       out  5  write word index to decoder5_32 data_in
//  rd_addr       out  5  read-mux select (word at head of queue)
//  count         out  6  occupancy 0..32
//  full/empty    out  1  count==32 / count==0
//  almost_full   out  1  count >= AFULL_TH
//  almost_empty  out  1  count <= AEMPTY_TH
//  ovf_err       out  1  sticky: write requested while full and not accepted
//  udf_err       out  1  sticky: read requested while empty
// BEHAVIOUR
//  - Reset (rst=1 at edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0,
//    almost_empty=1, almost_full=0, ovf_err=udf_err=0. rst overrides all
//    requests that cycle, including mid-burst; array contents are not cleared.
//  - Pointers are ADDR_W+1 bits (wrap bit); wr_addr/rd_addr = low 5 bits,
//    registered. Increment wraps 31->0 with wrap-bit toggle.
//  - wr_ack = wr_req & ~full; rd_ack = rd_req & ~empty. Both computed from
//    registered flags, so same-cycle read does NOT free space for a write
//    while full and same-cycle write does NOT make data readable while empty.
//  - Storage captures data at the edge ending a cycle with wr_sel_en=1 into
//    the word at wr_addr. Read data is the word at rd_addr (first-word
//    fall-through); consumer samples it in the rd_ack cycle.
//  - Next count: +1 on write only, -1 on read only, unchanged on both or
//    neither. Flags are registered and derived from the next count, so they
//    are valid the cycle after the access; never 33 or underflow below 0.
//  - ovf_err sets on wr_req & full; udf_err sets on rd_req & empty. Both hold
//    until err_clr or rst; a new error in the err_clr cycle wins (stays set).
//  - Invariant: full implies wr_ptr^rd_ptr == 6'b100000; empty implies
//    wr_ptr==rd_ptr.
//  - Controller has no FSM beyond pointer/count state; no bubbles, one
//    access per port per cycle sustained.
// TESTING
//  1 rst, then 32 writes back-to-back -> wr_addr 0..31, count=32, full=1,
//    almost_full from count 28; 33rd wr_req -> wr_ack=0, ovf_err=1.
//  2 From full, 32 reads -> rd_addr 0..31, data in write order, empty=1,
//    almost_empty from count 4; extra rd_req -> rd_ack=0, udf_err=1.
//  3 Wrap: 20 writes, 20 reads, 20 writes -> wr_addr goes 31->0, count=20,
//    reads return correct order across wrap.
//  4 Simultaneous: count=10, wr_req=rd_req=1 for 5 cycles -> count stays 10;
//    at full both -> only rd_ack, count=31; at empty both -> only wr_ack, count=1.
//  5 err_clr pulse with no new error -> ovf/udf clear next cycle; err_clr
//    concurrent with wr_req while full -> ovf_err remains 1.
//  6 rst asserted at count=17 mid-burst -> next cycle count=0, empty=1,
//    wr_addr=rd_addr=0, no ack in rst cycle affects state.

Source files
------------

// File: rtl/fifo_ctrl5_32.sv
`default_nettype none
// ============================================================================
// Module  : fifo_ctrl5_32
// Brief   : Pointer/flag controller for a 32-entry register-file FIFO.
//           Generates write word-select and read-mux select, arbitrates
//           simultaneous requests, tracks occupancy, thresholds and errors.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_ctrl5_32 #(
    parameter int ADDR_W    = 5,
    parameter int AFULL_TH  = 28,
    parameter int AEMPTY_TH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              err_clr,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic              wr_sel_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int            c_DEPTH_INT = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH   = c_DEPTH_INT[ADDR_W:0];
    localparam logic [ADDR_W:0] c_AFULL   = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_AEMPTY  = AEMPTY_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] c_ONE     = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [ADDR_W:0] r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_almost_full;
    logic            r_almost_empty;
    logic            r_ovf_err;
    logic            r_udf_err;

    logic            w_wr_ack;
    logic            w_rd_ack;
    logic [ADDR_W:0] w_count_nxt;

    // Acks use only registered flags: a same-cycle read never frees room for
    // a write when full, and a same-cycle write is never readable when empty.
    assign w_wr_ack = wr_req & ~r_full;
    assign w_rd_ack = rd_req & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_ack, w_rd_ack})
            2'b10:   w_count_nxt = r_count + c_ONE;
            2'b01:   w_count_nxt = r_count - c_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_ovf_err      <= 1'b0;
            r_udf_err      <= 1'b0;
        end else begin
            if (w_wr_ack) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_rd_ack) r_rd_ptr <= r_rd_ptr + c_ONE;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_DEPTH);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= c_AFULL);
            r_almost_empty <= (w_count_nxt <= c_AEMPTY);
            // A new error in the clear cycle keeps the flag set.
            r_ovf_err      <= (wr_req & r_full)  | (r_ovf_err & ~err_clr);
            r_udf_err      <= (rd_req & r_empty) | (r_udf_err & ~err_clr);
        end
    end

    assign wr_ack       = w_wr_ack;
    assign rd_ack       = w_rd_ack;
    assign wr_sel_en    = w_wr_ack;
    assign wr_addr      = r_wr_ptr[ADDR_W-1:0];
    assign rd_addr      = r_rd_ptr[ADDR_W-1:0];
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign ovf_err      = r_ovf_err;
    assign udf_err      = r_udf_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl5_32.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_ctrl5_32
// Brief   : Directed bench for fifo_ctrl5_32 with a local storage array.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl5_32;

    logic       clk;
    logic       rst;
    logic       wr_req;
    logic       rd_req;
    logic       err_clr;
    logic       wr_ack;
    logic       rd_ack;
    logic       wr_sel_en;
    logic [4:0] wr_addr;
    logic [4:0] rd_addr;
    logic [5:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       ovf_err;
    logic       udf_err;

    fifo_ctrl5_32 dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .err_clr      (err_clr),
        .wr_ack       (wr_ack),
        .rd_ack       (rd_ack),
        .wr_sel_en    (wr_sel_en),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage array driven by the controller's word select.
    logic [7:0] mem [0:31];
    logic [7:0] wdata;
    always @(posedge clk) if (wr_sel_en) mem[wr_addr] <= wdata;

    typedef struct {
        logic w, r, c, x;
        logic ewa, era;
        int   ecnt;
        logic eovf, eudf;
    } vec_t;

    vec_t       vecs [9];
    int         n_err;
    int         n_checks;
    logic [7:0] next_data;
    logic [7:0] q [$];
    logic [5:0] mwp;
    logic [5:0] mrp;
    int         cnt;
    logic       eo;
    logic       eu;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input int ecnt, input logic eovf, input logic eudf);
        chk("count", {26'd0, count}, ecnt);
        chk("full", full, ecnt == 32);
        chk("empty", empty, ecnt == 0);
        chk("almost_full", almost_full, ecnt >= 28);
        chk("almost_empty", almost_empty, ecnt <= 4);
        chk("ovf_err", ovf_err, eovf);
        chk("udf_err", udf_err, eudf);
        chk("wr_addr", wr_addr, mwp[4:0]);
        chk("rd_addr", rd_addr, mrp[4:0]);
    endtask

    // Starts at posedge+1, checks acks at negedge, state at next posedge+1.
    task automatic do_cycle(input logic w, r, c, x, input logic ewa, era,
                            input int ecnt, input logic eovf, eudf);
        wr_req  = w;
        rd_req  = r;
        err_clr = c;
        rst     = x;
        wdata   = next_data;
        next_data = next_data + 8'd1;
        @(negedge clk);
        chk("wr_ack", wr_ack, ewa);
        chk("rd_ack", rd_ack, era);
        chk("wr_sel_en", wr_sel_en, ewa);
        if (era && q.size() != 0) begin
            chk("rd_data", mem[rd_addr], q[0]);
            void'(q.pop_front());
        end
        if (ewa) q.push_back(wdata);
        if (x) begin
            q.delete();
            mwp = '0;
            mrp = '0;
        end else begin
            mwp = mwp + {5'd0, ewa};
            mrp = mrp + {5'd0, era};
        end
        @(posedge clk);
        #1;
        chk_state(ecnt, eovf, eudf);
    endtask

    task automatic wr_n(input int n);
        for (int i = 0; i < n; i++) begin
            do_cycle(1, 0, 0, 0, 1, 0, cnt + 1, eo, eu);
            cnt++;
        end
    endtask

    task automatic rd_n(input int n);
        for (int i = 0; i < n; i++) begin
            do_cycle(0, 1, 0, 0, 0, 1, cnt - 1, eo, eu);
            cnt--;
        end
    endtask

    task automatic do_reset();
        do_cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cnt = 0;
        eo  = 1'b0;
        eu  = 1'b0;
    endtask

    initial begin
        n_err = 0;
        n_checks = 0;
        next_data = 8'h10;
        mwp = '0;
        mrp = '0;
        cnt = 0;
        eo = 1'b0;
        eu = 1'b0;
        rst = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        err_clr = 1'b0;
        wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk_state(0, 0, 0);

        // Short directed vectors: w r c x | wr_ack rd_ack | count ovf udf
        vecs[0] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};  // read on empty
        vecs[1] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};  // clear
        vecs[2] = '{1, 0, 0, 0, 1, 0, 1, 0, 0};  // write
        vecs[3] = '{1, 1, 0, 0, 1, 1, 1, 0, 0};  // both at count 1
        vecs[4] = '{0, 1, 0, 0, 0, 1, 0, 0, 0};  // read to empty
        vecs[5] = '{1, 1, 0, 0, 1, 0, 1, 0, 1};  // both at empty
        vecs[6] = '{0, 1, 1, 0, 0, 1, 0, 0, 0};  // clear, no new error
        vecs[7] = '{0, 1, 1, 0, 0, 0, 0, 0, 1};  // new error wins over clear
        vecs[8] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};  // clear
        for (int i = 0; i < 9; i++)
            do_cycle(vecs[i].w, vecs[i].r, vecs[i].c, vecs[i].x, vecs[i].ewa,
                     vecs[i].era, vecs[i].ecnt, vecs[i].eovf, vecs[i].eudf);

        // Fill to full, then overflow attempt
        do_reset();
        wr_n(32);
        do_cycle(1, 0, 0, 0, 0, 0, 32, 1, 0);
        eo = 1'b1;

        // Drain in write order, then underflow attempt
        rd_n(32);
        do_cycle(0, 1, 0, 0, 0, 0, 0, 1, 1);
        eu = 1'b1;
        do_cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        eo = 1'b0;
        eu = 1'b0;

        // Pointer wrap
        do_reset();
        wr_n(20);
        rd_n(20);
        wr_n(20);
        chk("wrap_wr_addr", wr_addr, 5'd8);
        rd_n(20);

        // Simultaneous requests at mid, full and empty
        do_reset();
        wr_n(10);
        for (int i = 0; i < 5; i++) do_cycle(1, 1, 0, 0, 1, 1, 10, 0, 0);
        wr_n(22);
        do_cycle(1, 1, 0, 0, 0, 1, 31, 1, 0);
        eo = 1'b1;
        cnt = 31;
        rd_n(31);
        do_cycle(1, 1, 0, 0, 1, 0, 1, 1, 1);
        cnt = 1;
        eu = 1'b1;

        // Error clear behaviour
        do_cycle(0, 0, 1, 0, 0, 0, 1, 0, 0);
        eo = 1'b0;
        eu = 1'b0;
        wr_n(31);
        do_cycle(1, 0, 0, 0, 0, 0, 32, 1, 0);
        do_cycle(1, 0, 1, 0, 0, 0, 32, 1, 0);

        // Reset mid-burst overrides acked requests
        do_reset();
        wr_n(17);
        do_cycle(1, 1, 0, 1, 1, 1, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
